pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor, WIDTH bits split into STAGES equal slices.
- Each stage resolves one slice's carry chain and registers it.
- Operands enter and results leave through valid/ready handshakes with full backpressure.
- Used as the datapath arithmetic primitive wherever a wide add, subtract or compare must close timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; slice width SW = WIDTH/STAGES; must be ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept operand beat
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a-b-cin
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  raw carry out of MSB (sub mode: 1 = no borrow)
- ovf  out  1  signed overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all stage valid bits, out_valid, sum, cout and ovf are 0. in_ready is 1 out of reset.
- Arithmetic: effective B = sub ? ~b : b; effective carry-in = sub ? ~cin : cin.
  - Result = a + effB + effCin, computed at WIDTH+1 bits.
  - cout = bit WIDTH of that result.
  - ovf = (a[MSB] == effB[MSB]) && (sum[MSB] != a[MSB]).
- Pipeline: stage k (0..STAGES-1) adds slice bits [k*SW +: SW] using the carry registered by stage k-1 (stage 0 uses effCin).
  - Unconsumed upper operand slices are carried forward in stage registers.
  - Already-computed lower sum slices are carried forward in stage registers.
  - Sub-mode inversion happens at stage 0 capture.
- Latency: exactly STAGES cycles from an accepted input beat to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Enable: adv = out_ready | ~out_valid.
  - All stage registers, including valid bits, load only when adv=1.
  - When adv=0 the whole pipeline holds; sum/cout/ovf stay stable while out_valid=1.
- Handshake:
  - in_ready = adv, combinational from out_ready and out_valid.
  - An input beat is accepted iff in_valid & in_ready.
  - Data-path registers may load on invalid beats; only the valid bits are reset-qualified.
  - Bubbles propagate; no bubble collapsing.
- Ordering: results emerge strictly in acceptance order; none are lost or duplicated under any out_ready pattern.
- Output hold: once out_valid=1, sum/cout/ovf/out_valid must not change until out_ready=1.
- Simultaneous events: in the same cycle, an output beat can be consumed and an input beat accepted when the pipe is full.
- Reset mid-operation: all in-flight beats are discarded immediately and asynchronously. out_valid drops to 0 without waiting for a clock.
- STAGES=1: a single registered adder with latency 1, same handshake.
- Wrap-around: the sum is modulo 2^WIDTH. For example, max+1 gives 0 with cout=1.

Decomposition:
- Shared package holds:
  - the localparam helper for SW;
  - a typedef for the stage record (valid, carry, sum-so-far, remaining A/B, sub-mode-applied flag);
  - an elaboration-time check that WIDTH % STAGES == 0.
- One sub-module, addsub_slice: combinational SW-bit adder taking a, b and cin, producing s, cout, and the carry into its MSB (for ovf).
- The top level instantiates STAGES slices and the stage registers.

Test Plan (WIDTH=8, STAGES=4 unless stated):
- Reset, then a=0x3C, b=0x15, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles after acceptance, sum=0x51, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- sub=1: a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0 (borrow), ovf=0. a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Back-to-back: 16 consecutive beats a=i, b=2i, out_ready=1 -> 16 results 3i in order, one per cycle, in_ready constantly 1.
- Backpressure: stream 8 beats while out_ready toggles with a random 50% pattern -> every result is held stable while stalled, no loss or duplication, and in_ready=0 exactly when out_valid=1 & out_ready=0.
- Mid-stream rst_n pulse with 3 beats in flight -> out_valid drops asynchronously to 0, and no stale result appears after release. Repeat the first scenario with WIDTH=32, STAGES=1 and with WIDTH=32, STAGES=8; latencies must be 1 and 8.

Source files
------------

// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: slice sizing,
// configuration legality and the per-stage control record.
package pipelined_addsub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // Width of the slice that each pipeline stage resolves.
  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // A legal configuration splits WIDTH evenly into at least one stage.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && ((width % stages) == 0);
  endfunction

  // Control part of a stage record. The operand and partial-sum fields are
  // WIDTH dependent, so they live beside this record in the top level.
  // Operand B is already inverted for subtraction when it is captured at
  // stage 0, so later stages never look at the sub flag.
  typedef struct packed {
    logic valid;   // stage holds an accepted beat
    logic carry;   // carry out of the slice this stage resolved
  } stage_ctl_t;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand / result handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Side that issues operands and consumes results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // The arithmetic block itself.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/addsub_slice.sv
// Combinational SW-bit ripple-carry slice. cmsb is the carry into the slice
// MSB; xor-ed with cout it gives signed overflow when this is the top slice.
module addsub_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          cmsb
);

  logic [SW:0] c;

  // Ripple the carry bit by bit across the slice.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SW; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SW];
  assign cmsb = c[SW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor. Stage k resolves bits
// [k*SW +: SW] with the carry registered by stage k-1. The whole pipe
// advances as one when the output register is empty or being consumed.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave bus
);

  localparam int SW = slice_w(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] ONES = '1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  stage_ctl_t       ctl_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             ovf_q;

  logic [SW-1:0]    sl_a  [STAGES];
  logic [SW-1:0]    sl_b  [STAGES];
  logic [SW-1:0]    sl_s  [STAGES];
  logic             sl_ci [STAGES];
  logic             sl_co [STAGES];
  logic             sl_cm [STAGES];

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  // Subtraction is a + ~b + ~cin; applied once, at capture.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub ? ~bus.cin : bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - SW)) << (k * SW);

    if (k == 0) begin : g_src
      assign sl_a[k]  = bus.a[0 +: SW];
      assign sl_b[k]  = b_eff[0 +: SW];
      assign sl_ci[k] = c_eff;
      assign s_nxt[k] = WIDTH'(sl_s[k]);
    end else begin : g_src
      assign sl_a[k]  = a_q[k-1][k*SW +: SW];
      assign sl_b[k]  = b_q[k-1][k*SW +: SW];
      assign sl_ci[k] = ctl_q[k-1].carry;
      assign s_nxt[k] = (s_q[k-1] & ~MASK) | (WIDTH'(sl_s[k]) << (k * SW));
    end

    addsub_slice #(
      .SW (SW)
    ) u_slice (
      .a    (sl_a[k]),
      .b    (sl_b[k]),
      .cin  (sl_ci[k]),
      .s    (sl_s[k]),
      .cout (sl_co[k]),
      .cmsb (sl_cm[k])
    );
  end

  // Stage registers: all load together on adv; reset discards every beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      ctl_q[0] <= '{valid: bus.in_valid, carry: sl_co[0]};
      a_q[0]   <= bus.a;
      b_q[0]   <= b_eff;
      s_q[0]   <= s_nxt[0];
      for (int k = 1; k < STAGES; k++) begin
        ctl_q[k] <= '{valid: ctl_q[k-1].valid, carry: sl_co[k]};
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        s_q[k]   <= s_nxt[k];
      end
      ovf_q <= sl_co[STAGES-1] ^ sl_cm[STAGES-1];
    end
  end

  assign bus.out_valid = ctl_q[STAGES-1].valid;
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = ctl_q[STAGES-1].carry;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: an 8-bit/4-stage instance carries
// most scenarios; 32-bit/1-stage and 32-bit/8-stage instances check latency.
module tb_pipelined_addsub;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(8))  ifm ();
  pipelined_addsub_if #(.WIDTH(32)) if1 ();
  pipelined_addsub_if #(.WIDTH(32)) if8 ();

  pipelined_addsub #(.WIDTH(8),  .STAGES(4)) u_m  (.clk(clk), .rst_n(rst_n), .bus(ifm));
  pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pipelined_addsub #(.WIDTH(32), .STAGES(8)) u_s8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t qm[$], q1[$], q8[$];
  exp_t em, e1, e8;
  int total = 0, bad = 0, cyc = 0, rx_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  function automatic void check1(input string name, input logic act, input logic req);
    check(name, {31'b0, act}, {31'b0, req});
  endfunction

  function automatic void fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endfunction

  function automatic void cmp_beat(input string tag, input exp_t e, input logic [31:0] s,
                                   input logic co, input logic ov, input int stages);
    check({tag, " sum"}, s, e.sum);
    check1({tag, " cout"}, co, e.cout);
    check1({tag, " ovf"}, ov, e.ovf);
    if (e.chk_lat) check({tag, " latency"}, 32'(cyc - e.acc), 32'(stages));
  endfunction

  // Main monitor: handshake relation, output hold while stalled, in-order results.
  logic       stall = 1'b0;
  logic [7:0] hs;
  logic       hc, ho;

  always @(negedge rst_n) stall = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check1("w8 in_ready", ifm.in_ready, ~(ifm.out_valid & ~ifm.out_ready));
      if (stall) begin
        check1("w8 hold out_valid", ifm.out_valid, 1'b1);
        check("w8 hold sum", {24'b0, ifm.sum}, {24'b0, hs});
        check1("w8 hold cout", ifm.cout, hc);
        check1("w8 hold ovf", ifm.ovf, ho);
      end
      if (ifm.out_valid && ifm.out_ready) begin
        if (qm.size() == 0) fail("w8 unexpected result");
        else begin
          em = qm.pop_front();
          cmp_beat("w8", em, {24'b0, ifm.sum}, ifm.cout, ifm.ovf, 4);
          rx_m++;
        end
      end
      stall = ifm.out_valid & ~ifm.out_ready;
      hs    = ifm.sum;
      hc    = ifm.cout;
      ho    = ifm.ovf;
    end
  end

  // Monitors for the 32-bit instances (out_ready held high).
  always @(negedge clk) begin
    if (rst_n && if1.out_valid) begin
      if (q1.size() == 0) fail("s1 unexpected result");
      else begin
        e1 = q1.pop_front();
        cmp_beat("s1", e1, if1.sum, if1.cout, if1.ovf, 1);
      end
    end
    if (rst_n && if8.out_valid) begin
      if (q8.size() == 0) fail("s8 unexpected result");
      else begin
        e8 = q8.pop_front();
        cmp_beat("s8", e8, if8.sum, if8.cout, if8.ovf, 8);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                      input logic [7:0] es, input logic ec, input logic eo, input bit lat);
    exp_t e;
    int   n;
    n = 0;
    ifm.a = a; ifm.b = b; ifm.cin = cin; ifm.sub = sub; ifm.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ifm.in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) fail("w8 send timeout");
    else begin
      e = '{{24'b0, es}, ec, eo, cyc, lat};
      qm.push_back(e);
    end
    @(posedge clk); #1;
    ifm.in_valid = 1'b0;
  endtask

  task automatic send_w(input bit eight, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub,
                        input logic [31:0] es, input logic ec, input logic eo);
    exp_t e;
    if (eight) begin
      if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub; if8.in_valid = 1'b1;
    end else begin
      if1.a = a; if1.b = b; if1.cin = cin; if1.sub = sub; if1.in_valid = 1'b1;
    end
    @(negedge clk);
    e = '{es, ec, eo, cyc, 1'b1};
    if (eight) begin
      check1("s8 in_ready", if8.in_ready, 1'b1);
      q8.push_back(e);
    end else begin
      check1("s1 in_ready", if1.in_ready, 1'b1);
      q1.push_back(e);
    end
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if1.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((qm.size() + q1.size() + q8.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if ((qm.size() + q1.size() + q8.size()) != 0) fail("drain timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ifm.in_valid = 0; ifm.a = '0; ifm.b = '0; ifm.cin = 0; ifm.sub = 0; ifm.out_ready = 1;
    if1.in_valid = 0; if1.a = '0; if1.b = '0; if1.cin = 0; if1.sub = 0; if1.out_ready = 1;
    if8.in_valid = 0; if8.a = '0; if8.b = '0; if8.cin = 0; if8.sub = 0; if8.out_ready = 1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check1("reset out_valid", ifm.out_valid, 1'b0);
    check("reset sum", {24'b0, ifm.sum}, 32'h0);
    check1("reset cout", ifm.cout, 1'b0);
    check1("reset ovf", ifm.ovf, 1'b0);
    check1("reset in_ready", ifm.in_ready, 1'b1);
    check1("reset s1 out_valid", if1.out_valid, 1'b0);
    check1("reset s8 out_valid", if8.out_valid, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First beat with latency check.
    send(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0, 1'b1);
    wait_empty();

    // Wrap-around, overflow and subtract vectors.
    send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    send(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    send(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    send(8'h0F, 8'h10, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0);
    send(8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b0);
    wait_empty();

    // Back-to-back stream: every beat must come out exactly 4 cycles later.
    for (int i = 0; i < 16; i++) begin
      check1("b2b in_ready", ifm.in_ready, 1'b1);
      send(8'(i), 8'(2 * i), 1'b0, 1'b0, 8'(3 * i), 1'b0, 1'b0, 1'b1);
    end
    wait_empty();

    // Random backpressure while streaming.
    rx_m = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] ta, tb;
          logic [8:0] f;
          ta = 8'(i * 37 + 5);
          tb = 8'(8'h60 + i * 9);
          f  = {1'b0, ta} + {1'b0, tb};
          send(ta, tb, 1'b0, 1'b0, f[7:0], f[8], (ta[7] == tb[7]) && (f[7] != ta[7]), 1'b0);
        end
      end
      begin
        int n;
        n = 0;
        while (rx_m < 8 && n < 400) begin
          @(posedge clk); #1;
          ifm.out_ready = 1'($urandom_range(0, 1));
          n++;
        end
        if (rx_m < 8) fail("backpressure timeout");
        ifm.out_ready = 1'b1;
      end
    join
    wait_empty();

    // Reset with three beats in flight, the oldest sitting at the output.
    send(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    send(8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    send(8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    check1("pre-reset out_valid", ifm.out_valid, 1'b1);
    qm.delete();
    rst_n = 1'b0;
    #1;
    check1("async reset out_valid", ifm.out_valid, 1'b0);
    check1("async reset in_ready", ifm.in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check1("no stale out_valid", ifm.out_valid, 1'b0);
    send(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0, 1'b1);
    wait_empty();

    // 32-bit single-stage and eight-stage instances.
    send_w(1'b0, 32'h0000003C, 32'h00000015, 1'b0, 1'b0, 32'h00000051, 1'b0, 1'b0);
    send_w(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    send_w(1'b1, 32'h0000003C, 32'h00000015, 1'b0, 1'b0, 32'h00000051, 1'b0, 1'b0);
    send_w(1'b1, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    send_w(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
